// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - RV32IM opcodes, ALU select codes and decode control types
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b10000;
  localparam logic [4:0] ALU_SRA    = 5'b10101;
  localparam logic [4:0] ALU_JUMP   = 5'b10001;
  localparam logic [4:0] ALU_MUL    = 5'b11000;
  localparam logic [4:0] ALU_MULH   = 5'b11001;
  localparam logic [4:0] ALU_MULHSU = 5'b11010;
  localparam logic [4:0] ALU_MULHU  = 5'b11011;
  localparam logic [4:0] ALU_DIV    = 5'b11100;
  localparam logic [4:0] ALU_REM    = 5'b11101;
  localparam logic [4:0] ALU_LUI    = 5'b11110;
  localparam logic [4:0] ALU_REMU   = 5'b11111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [4:0] alu_sel;
    logic       op1_pc;
    logic       op2_imm;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       rs1_used;
    logic       rs2_used;
    imm_type_e  imm_type;
  } ctrl_t;

  // Signed and unsigned divide share one ALU code.
  function automatic logic [4:0] muldiv_sel(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_MUL;
      3'b001:  return ALU_MULH;
      3'b010:  return ALU_MULHSU;
      3'b011:  return ALU_MULHU;
      3'b100,
      3'b101:  return ALU_DIV;
      3'b110:  return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/id_ex_decode_stage_if.sv
// rtl/id_ex_decode_stage_if.sv - IF/ID inputs and ID/EX outputs of the decode stage
interface id_ex_decode_stage_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic [31:0]     INSTR_IN;
  logic [XLEN-1:0] PC_IN;
  logic            VALID_IN;
  logic            STALL_IN;
  logic            FLUSH;
  logic            STALL_OUT;
  logic [4:0]      ALU_SELECT;
  logic [XLEN-1:0] IMM_OUT;
  logic [XLEN-1:0] PC_OUT;
  logic [REG_AW-1:0] RS1_OUT;
  logic [REG_AW-1:0] RS2_OUT;
  logic [REG_AW-1:0] RD_OUT;
  logic            OP1_PC_SEL;
  logic            OP2_IMM_SEL;
  logic            REG_WRITE_EN;
  logic            MEM_READ;
  logic            MEM_WRITE;
  logic [2:0]      MEM_FUNCT3;
  logic [1:0]      WB_SEL;
  logic            VALID_OUT;
  logic            ILLEGAL_OUT;

  modport master (
    output INSTR_IN, PC_IN, VALID_IN, STALL_IN, FLUSH,
    input  STALL_OUT, ALU_SELECT, IMM_OUT, PC_OUT, RS1_OUT, RS2_OUT, RD_OUT,
           OP1_PC_SEL, OP2_IMM_SEL, REG_WRITE_EN, MEM_READ, MEM_WRITE,
           MEM_FUNCT3, WB_SEL, VALID_OUT, ILLEGAL_OUT
  );

  modport slave (
    input  INSTR_IN, PC_IN, VALID_IN, STALL_IN, FLUSH,
    output STALL_OUT, ALU_SELECT, IMM_OUT, PC_OUT, RS1_OUT, RS2_OUT, RD_OUT,
           OP1_PC_SEL, OP2_IMM_SEL, REG_WRITE_EN, MEM_READ, MEM_WRITE,
           MEM_FUNCT3, WB_SEL, VALID_OUT, ILLEGAL_OUT
  );
endinterface

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - combinational RV32I immediate generator
module rv_imm_gen
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/id_ex_decode_stage.sv
// rtl/id_ex_decode_stage.sv - RV32IM decode, load-use hazard detect and ID/EX register
module id_ex_decode_stage
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input logic CLK,
  input logic RESET,
  id_ex_decode_stage_if.slave bus
);
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rs1, rs2, rd;
  ctrl_t             dec;
  logic [XLEN-1:0]   imm;
  logic              hazard;

  assign opcode = bus.INSTR_IN[6:0];
  assign funct3 = bus.INSTR_IN[14:12];
  assign funct7 = bus.INSTR_IN[31:25];
  assign rd     = bus.INSTR_IN[11:7];
  assign rs1    = bus.INSTR_IN[19:15];
  assign rs2    = bus.INSTR_IN[24:20];

  always_comb begin
    dec = '0;
    case (opcode)
      OPC_OP_IMM: begin
        dec.rs1_used = 1'b1; dec.op2_imm = 1'b1; dec.reg_we = 1'b1;
        dec.imm_type = IMM_I; dec.alu_sel = {2'b00, funct3};
        if (funct3 == 3'b001 && funct7 != 7'b0) dec.illegal = 1'b1;
        else if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000) dec.alu_sel = ALU_SRA;
          else if (funct7 != 7'b0) dec.illegal = 1'b1;
        end
      end
      OPC_OP: begin
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.reg_we = 1'b1;
        case (funct7)
          7'b0000000: dec.alu_sel = {2'b00, funct3};
          7'b0000001: dec.alu_sel = muldiv_sel(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000) dec.alu_sel = ALU_SUB;
            else if (funct3 == 3'b101) dec.alu_sel = ALU_SRA;
            else dec.illegal = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.imm_type = IMM_B;
        dec.alu_sel = {2'b01, funct3};
        dec.illegal = (funct3[2:1] == 2'b01);
      end
      OPC_JAL, OPC_JALR: begin
        dec.alu_sel = ALU_JUMP; dec.op1_pc = 1'b1; dec.op2_imm = 1'b1;
        dec.reg_we = 1'b1; dec.wb_sel = WB_PC4;
        dec.imm_type = (opcode == OPC_JAL) ? IMM_J : IMM_I;
        dec.rs1_used = (opcode == OPC_JALR);
        dec.illegal = (opcode == OPC_JALR) && (funct3 != 3'b000);
      end
      OPC_LUI: begin
        dec.alu_sel = ALU_LUI; dec.op2_imm = 1'b1; dec.reg_we = 1'b1; dec.imm_type = IMM_U;
      end
      OPC_AUIPC: begin
        dec.op1_pc = 1'b1; dec.op2_imm = 1'b1; dec.reg_we = 1'b1; dec.imm_type = IMM_U;
      end
      OPC_LOAD: begin
        dec.rs1_used = 1'b1; dec.op2_imm = 1'b1; dec.reg_we = 1'b1; dec.mem_rd = 1'b1;
        dec.wb_sel = WB_MEM; dec.imm_type = IMM_I;
        dec.illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.op2_imm = 1'b1;
        dec.mem_wr = 1'b1; dec.imm_type = IMM_S;
        dec.illegal = (funct3 >= 3'b011);
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal instruction must not write, access memory or raise a hazard.
    if (dec.illegal) begin
      dec = '0;
      dec.illegal = 1'b1;
    end
    if (rd == '0) dec.reg_we = 1'b0;
  end

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (bus.INSTR_IN),
    .imm_type (dec.imm_type),
    .imm      (imm)
  );

  assign hazard = bus.VALID_OUT && bus.MEM_READ && (bus.RD_OUT != '0) && bus.VALID_IN &&
                  ((dec.rs1_used && rs1 == bus.RD_OUT) || (dec.rs2_used && rs2 == bus.RD_OUT));
  assign bus.STALL_OUT = RESET && hazard && !bus.FLUSH && !bus.STALL_IN;

  // Reset, flush, hazard and empty input all load the same all-zero bubble.
  always_ff @(posedge CLK) begin
    if (!RESET || bus.FLUSH || (!bus.STALL_IN && (hazard || !bus.VALID_IN))) begin
      bus.ALU_SELECT   <= ALU_ADD;
      bus.IMM_OUT      <= '0;
      bus.PC_OUT       <= '0;
      bus.RS1_OUT      <= '0;
      bus.RS2_OUT      <= '0;
      bus.RD_OUT       <= '0;
      bus.OP1_PC_SEL   <= 1'b0;
      bus.OP2_IMM_SEL  <= 1'b0;
      bus.REG_WRITE_EN <= 1'b0;
      bus.MEM_READ     <= 1'b0;
      bus.MEM_WRITE    <= 1'b0;
      bus.MEM_FUNCT3   <= '0;
      bus.WB_SEL       <= WB_ALU;
      bus.VALID_OUT    <= 1'b0;
      bus.ILLEGAL_OUT  <= 1'b0;
    end else if (!bus.STALL_IN) begin
      bus.ALU_SELECT   <= dec.alu_sel;
      bus.IMM_OUT      <= imm;
      bus.PC_OUT       <= bus.PC_IN;
      bus.RS1_OUT      <= rs1;
      bus.RS2_OUT      <= rs2;
      bus.RD_OUT       <= rd;
      bus.OP1_PC_SEL   <= dec.op1_pc;
      bus.OP2_IMM_SEL  <= dec.op2_imm;
      bus.REG_WRITE_EN <= dec.reg_we;
      bus.MEM_READ     <= dec.mem_rd;
      bus.MEM_WRITE    <= dec.mem_wr;
      bus.MEM_FUNCT3   <= funct3;
      bus.WB_SEL       <= dec.wb_sel;
      bus.VALID_OUT    <= 1'b1;
      bus.ILLEGAL_OUT  <= dec.illegal;
    end
  end
endmodule

// File: tb/tb_id_ex_decode_stage.sv
// tb/tb_id_ex_decode_stage.sv - directed self-checking bench for id_ex_decode_stage
module tb_id_ex_decode_stage;
  logic CLK = 1'b0;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  id_ex_decode_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

  id_ex_decode_stage #(.XLEN(32), .REG_AW(5)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0000A283;
  localparam logic [31:0] I_ADD  = 32'h00228333;
  localparam logic [31:0] I_BEQ  = 32'hFE208CE3;
  localparam logic [31:0] I_DIVU = 32'h029453B3;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_ADDI = 32'h00100013;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h12345237;

  initial begin
    RESET = 1'b0;
    bus.INSTR_IN = I_SUB;
    bus.PC_IN    = 32'h100;
    bus.VALID_IN = 1'b1;
    bus.STALL_IN = 1'b0;
    bus.FLUSH    = 1'b0;
    step();
    step();
    check("rst_valid", bus.VALID_OUT, 0);
    check("rst_alu", bus.ALU_SELECT, 0);
    check("rst_rd", bus.RD_OUT, 0);
    check("rst_we", bus.REG_WRITE_EN, 0);
    check("rst_pc", bus.PC_OUT, 0);
    check("rst_imm", bus.IMM_OUT, 0);
    check("rst_stall", bus.STALL_OUT, 0);

    RESET = 1'b1;
    step();
    check("sub_alu", bus.ALU_SELECT, 5'b10000);
    check("sub_rd", bus.RD_OUT, 3);
    check("sub_rs1", bus.RS1_OUT, 1);
    check("sub_rs2", bus.RS2_OUT, 2);
    check("sub_we", bus.REG_WRITE_EN, 1);
    check("sub_op2imm", bus.OP2_IMM_SEL, 0);
    check("sub_valid", bus.VALID_OUT, 1);
    check("sub_pc", bus.PC_OUT, 32'h100);

    bus.INSTR_IN = I_LW; bus.PC_IN = 32'h104;
    step();
    check("lw_memrd", bus.MEM_READ, 1);
    check("lw_rd", bus.RD_OUT, 5);
    check("lw_wbsel", bus.WB_SEL, 2'b01);
    check("lw_f3", bus.MEM_FUNCT3, 3'b010);
    bus.INSTR_IN = I_ADD; bus.PC_IN = 32'h108;
    #1;
    check("hz_stall", bus.STALL_OUT, 1);
    step();
    check("hz_bubble_valid", bus.VALID_OUT, 0);
    check("hz_bubble_memrd", bus.MEM_READ, 0);
    check("hz_bubble_alu", bus.ALU_SELECT, 0);
    check("hz_stall_drop", bus.STALL_OUT, 0);
    step();
    check("add_valid", bus.VALID_OUT, 1);
    check("add_alu", bus.ALU_SELECT, 0);
    check("add_rd", bus.RD_OUT, 6);
    check("add_pc", bus.PC_OUT, 32'h108);

    bus.INSTR_IN = I_BEQ; bus.PC_IN = 32'h10C;
    step();
    check("beq_alu", bus.ALU_SELECT, 5'b01000);
    check("beq_imm", bus.IMM_OUT, 32'hFFFFFFF8);
    check("beq_we", bus.REG_WRITE_EN, 0);
    bus.FLUSH = 1'b1;
    step();
    check("flush_valid", bus.VALID_OUT, 0);
    check("flush_alu", bus.ALU_SELECT, 0);
    bus.FLUSH = 1'b0;

    bus.INSTR_IN = I_DIVU; bus.PC_IN = 32'h110;
    step();
    check("divu_alu", bus.ALU_SELECT, 5'b11100);
    bus.STALL_IN = 1'b1;
    bus.INSTR_IN = I_SUB;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("hold_alu_%0d", i), bus.ALU_SELECT, 5'b11100);
      check($sformatf("hold_rd_%0d", i), bus.RD_OUT, 7);
    end
    bus.FLUSH = 1'b1;
    step();
    check("flush_stall_valid", bus.VALID_OUT, 0);
    check("flush_stall_alu", bus.ALU_SELECT, 0);
    bus.FLUSH = 1'b0; bus.STALL_IN = 1'b0;

    bus.INSTR_IN = I_BAD;
    step();
    check("bad_illegal", bus.ILLEGAL_OUT, 1);
    check("bad_valid", bus.VALID_OUT, 1);
    check("bad_we", bus.REG_WRITE_EN, 0);
    check("bad_alu", bus.ALU_SELECT, 0);

    bus.INSTR_IN = I_ADDI;
    step();
    check("addi_illegal", bus.ILLEGAL_OUT, 0);
    check("addi_valid", bus.VALID_OUT, 1);
    check("addi_we", bus.REG_WRITE_EN, 0);
    check("addi_imm", bus.IMM_OUT, 1);

    bus.INSTR_IN = I_JAL;
    step();
    check("jal_alu", bus.ALU_SELECT, 5'b10001);
    check("jal_wbsel", bus.WB_SEL, 2'b10);
    check("jal_op1pc", bus.OP1_PC_SEL, 1);
    check("jal_imm", bus.IMM_OUT, 8);

    bus.INSTR_IN = I_LUI;
    step();
    check("lui_alu", bus.ALU_SELECT, 5'b11110);
    check("lui_imm", bus.IMM_OUT, 32'h12345000);
    check("lui_rd", bus.RD_OUT, 4);

    bus.VALID_IN = 1'b0;
    step();
    check("novalid_valid", bus.VALID_OUT, 0);
    bus.VALID_IN = 1'b1;

    bus.INSTR_IN = I_LW;
    step();
    bus.INSTR_IN = I_ADD;
    #1;
    check("rst_hz_stall", bus.STALL_OUT, 1);
    RESET = 1'b0;
    #1;
    check("rst_hz_gate", bus.STALL_OUT, 0);
    step();
    RESET = 1'b1;
    #1;
    check("rst_hz_valid", bus.VALID_OUT, 0);
    check("rst_hz_memrd", bus.MEM_READ, 0);
    check("rst_hz_stall_after", bus.STALL_OUT, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
